// File: rtl/if_buffer_pkg.sv
// Shared types and constants for the fetch-to-decode buffer.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package if_buffer_pkg;

  // Architectural register width; matches the core-wide XLEN.
  localparam int XLEN = 32;

  // Canonical no-op (addi x0, x0, 0) shown to decode whenever nothing is buffered.
  localparam logic [XLEN-1:0] INST_NOP = 32'h0000_0013;

  // One buffered fetch: the pc travels with its instruction word.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } ibuf_entry_t;

endpackage

// File: rtl/if_buffer_mem.sv
// Storage array for the fetch buffer: one write port, one asynchronous read port.
// Latency: write visible on the read port after the write edge; read is combinational.
// Backpressure: none here; the owner guarantees it never writes an occupied slot.
module if_buffer_mem
  import if_buffer_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic              clk,
  input  logic              we,
  input  logic [PTR_W-1:0]  waddr,
  input  ibuf_entry_t       wdata,
  input  logic [PTR_W-1:0]  raddr,
  output ibuf_entry_t       rdata
);

  ibuf_entry_t mem [DEPTH];

  // Capture the incoming entry; contents are never reset because the
  // pointers/count alone decide which slots are live.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/if_buffer.sv
// Fetch-to-decode decoupling FIFO holding {pc, inst} pairs from the ifu.
// Latency: 1 cycle from push edge to out_valid when the buffer was empty.
// Backpressure: in_ready drops when full (no same-cycle pass-through); flush empties it.
module if_buffer
  import if_buffer_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_inst,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_inst
);

  localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             push;
  logic             pop;
  ibuf_entry_t      wdata;
  ibuf_entry_t      rdata;

  // Ready depends on occupancy only, so a full buffer never forwards
  // a fetch straight through even if decode is draining this cycle.
  assign in_ready  = (count != CNT_FULL);
  assign out_valid = (count != '0);

  // Flush kills both handshakes so a redirect cannot leak a stale fetch.
  assign push = in_valid  & in_ready  & ~flush;
  assign pop  = out_valid & out_ready & ~flush;

  assign wdata.pc   = in_pc;
  assign wdata.inst = in_inst;

  // Pointer and occupancy tracking; flush outranks any same-cycle push/pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  if_buffer_mem #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr),
    .wdata (wdata),
    .raddr (rd_ptr),
    .rdata (rdata)
  );

  // Empty buffer shows a clean no-op at pc 0 instead of stale storage.
  assign out_pc   = out_valid ? rdata.pc   : '0;
  assign out_inst = out_valid ? rdata.inst : INST_NOP;

endmodule

// File: tb/tb_if_buffer.sv
module tb_if_buffer;
  import if_buffer_pkg::*;

  logic            clk;
  logic            rst_n;
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] in_pc;
  logic [XLEN-1:0] in_inst;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [XLEN-1:0] out_inst;

  int passed = 0;
  int total  = 0;

  ibuf_entry_t exp_q[$];

  if_buffer #(.DEPTH(4), .PTR_W(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pc     (in_pc),
    .in_inst   (in_inst),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pc    (out_pc),
    .out_inst  (out_inst)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
  endtask

  // Monitor: compares DUT outputs against the scoreboard front every cycle,
  // and retires the front entry when the model says decode consumes it.
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      check("out_valid", 32'(out_valid), 32'd1);
      check("out_pc",    out_pc,         exp_q[0].pc);
      check("out_inst",  out_inst,       exp_q[0].inst);
    end else begin
      check("out_valid_empty", 32'(out_valid), 32'd0);
      check("out_pc_empty",    out_pc,         32'd0);
      check("out_inst_empty",  out_inst,       INST_NOP);
    end
    check("in_ready", 32'(in_ready), 32'(exp_q.size() != 4));
    if (rst_n && !flush && out_ready && exp_q.size() != 0) begin
      void'(exp_q.pop_front());
    end
  end

  // One clock of stimulus; acc is the hand-computed acceptance of the push.
  task automatic step(input logic iv, input logic [31:0] pc, input logic [31:0] inst,
                      input logic ordy, input logic fl, input logic acc);
    ibuf_entry_t e;
    in_valid  = iv;
    in_pc     = pc;
    in_inst   = inst;
    out_ready = ordy;
    flush     = fl;
    @(posedge clk);
    if (fl) exp_q.delete();
    else if (acc) begin
      e.pc   = pc;
      e.inst = inst;
      exp_q.push_back(e);
    end
    #1;
  endtask

  task automatic idle(input logic ordy, input int n);
    for (int i = 0; i < n; i++) step(1'b0, 32'h0, 32'h0, ordy, 1'b0, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_pc = '0; in_inst = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    idle(1'b0, 2);

    // Single pass with decode ready.
    step(1'b1, 32'h100, 32'h0050_0093, 1'b1, 1'b0, 1'b1);
    idle(1'b1, 3);

    // Fill under stall, refused 5th push, then drain in order.
    step(1'b1, 32'h0, 32'hA000_0000, 1'b0, 1'b0, 1'b1);
    step(1'b1, 32'h4, 32'hA000_0004, 1'b0, 1'b0, 1'b1);
    step(1'b1, 32'h8, 32'hA000_0008, 1'b0, 1'b0, 1'b1);
    step(1'b1, 32'hC, 32'hA000_000C, 1'b0, 1'b0, 1'b1);
    step(1'b1, 32'h10, 32'hA000_0010, 1'b0, 1'b0, 1'b0);
    idle(1'b1, 6);

    // Wrap: hold two entries, then stream push+pop together for 10 cycles.
    step(1'b1, 32'h200, 32'hB000_0200, 1'b0, 1'b0, 1'b1);
    step(1'b1, 32'h204, 32'hB000_0204, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 32'h208 + 32'(4*i), 32'hC000_0000 + 32'(i), 1'b1, 1'b0, 1'b1);
    end
    idle(1'b1, 4);

    // Flush with a simultaneous push: held entries and pc 0x20 vanish.
    step(1'b1, 32'h300, 32'hD000_0300, 1'b0, 1'b0, 1'b1);
    step(1'b1, 32'h304, 32'hD000_0304, 1'b0, 1'b0, 1'b1);
    step(1'b1, 32'h308, 32'hD000_0308, 1'b0, 1'b0, 1'b1);
    step(1'b1, 32'h20, 32'hDEAD_0020, 1'b1, 1'b1, 1'b0);
    step(1'b1, 32'h40, 32'hE000_0040, 1'b1, 1'b0, 1'b1);
    idle(1'b1, 3);

    // Flush while empty.
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0);
    idle(1'b1, 1);

    // Asynchronous reset between edges with two entries held.
    step(1'b1, 32'h500, 32'hF000_0500, 1'b0, 1'b0, 1'b1);
    step(1'b1, 32'h504, 32'hF000_0504, 1'b0, 1'b0, 1'b1);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("async_rst_out_valid", 32'(out_valid), 32'd0);
    check("async_rst_out_inst",  out_inst,       INST_NOP);
    check("async_rst_out_pc",    out_pc,         32'd0);
    check("async_rst_in_ready",  32'(in_ready),  32'd1);
    @(posedge clk);
    #1 rst_n = 1'b1;
    idle(1'b1, 2);
    step(1'b1, 32'h600, 32'h1234_5678, 1'b1, 1'b0, 1'b1);
    idle(1'b1, 3);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
